// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: func codes, FSM states, op types.
package muldiv_pkg;

   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1A;
   localparam logic [5:0] FUNC_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   typedef enum logic {OP_MUL, OP_DIV} op_e;

   // mult/multu/div/divu occupy 0x18..0x1B
   function automatic logic is_mdu_op(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

   // mfhi/mthi/mflo/mtlo occupy 0x10..0x13
   function automatic logic is_hilo_op(input logic [5:0] f);
      return f[5:2] == 4'b0100;
   endfunction

   // even codes in the arithmetic group are the signed variants
   function automatic logic is_signed_op(input logic [5:0] f);
      return ~f[0];
   endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate; used for operand magnitude and result sign fix.
module muldiv_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   input  logic             neg,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// state | meaning
// IDLE  | waiting for mult/multu/div/divu; mthi/mtlo accepted
// CALC  | WIDTH shift-add or restoring shift-subtract steps
// FIX   | sign correction of product / quotient / remainder
// DONE  | HI/LO written at end of cycle; new op may start
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rtype,
   input  logic [5:0]       func,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rdata
);

   state_e state_q, state_d;
   op_e    op_q, op_d;
   logic   neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, divz_q, divz_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d, cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;

   logic             sgn_op, neg_a, neg_b, accept, mt_hi, mt_lo, div_ge;
   logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]   mul_sum, rem_sh;
   logic [WIDTH+1:0] diff;

   assign sgn_op = is_signed_op(func);
   assign neg_a  = sgn_op & a[WIDTH-1];
   assign neg_b  = sgn_op & b[WIDTH-1];

   muldiv_abs #(.WIDTH(WIDTH))   u_abs_a   (.din(a), .neg(neg_a), .dout(a_abs));
   muldiv_abs #(.WIDTH(WIDTH))   u_abs_b   (.din(b), .neg(neg_b), .dout(b_abs));
   muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prd (.din({acc_hi_q, acc_lo_q}), .neg(neg_lo_q), .dout(prod_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_quo (.din(acc_lo_q), .neg(neg_lo_q), .dout(quo_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_rem (.din(acc_hi_q), .neg(neg_hi_q), .dout(rem_fix));

   assign busy   = (state_q == CALC) || (state_q == FIX);
   assign done   = (state_q == DONE);
   assign accept = start & rtype & is_mdu_op(func) & ~busy;
   assign mt_hi  = start & rtype & (func == FUNC_MTHI) & ~busy;
   assign mt_lo  = start & rtype & (func == FUNC_MTLO) & ~busy;
   assign stall  = busy & rtype & (start | is_hilo_op(func));
   assign hi     = hi_q;
   assign lo     = lo_q;

   // multiply: {acc_hi, acc_lo} holds partial product over the shifting multiplier
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
   // divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
   assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign diff    = {1'b0, rem_sh} - {2'b00, opb_q};
   assign div_ge  = ~diff[WIDTH+1];

   always_comb begin
      rdata = '0;
      if (rtype && func == FUNC_MFHI)      rdata = hi_q;
      else if (rtype && func == FUNC_MFLO) rdata = lo_q;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      divz_d   = divz_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (mt_hi) hi_d = a;
      if (mt_lo) lo_d = a;

      case (state_q)
         CALC: begin
            cnt_d = cnt_q - WIDTH'(1);
            if (op_q == OP_MUL) begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end else begin
               acc_hi_d = div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            if (op_q == OP_MUL) begin
               {acc_hi_d, acc_lo_d} = prod_fix;
            end else begin
               acc_hi_d = rem_fix;
               acc_lo_d = divz_q ? '1 : quo_fix;
            end
            state_d = DONE;
         end
         DONE: begin
            // overrides any same-edge mthi/mtlo write
            hi_d    = acc_hi_q;
            lo_d    = acc_lo_q;
            state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         state_d  = CALC;
         op_d     = func[1] ? OP_DIV : OP_MUL;
         neg_lo_d = neg_a ^ neg_b;
         neg_hi_d = neg_a;
         divz_d   = func[1] & (b == '0);
         acc_hi_d = '0;
         acc_lo_d = a_abs;
         opb_d    = b_abs;
         cnt_d    = WIDTH'(WIDTH - 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         divz_q   <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         divz_q   <= divz_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule
